// File: rtl/program_loader.sv
// Byte-stream program loader: receives a length header, assembles little-endian
// words into instruction memory, verifies an XOR checksum and releases the core.
module program_loader #(
  parameter int DEPTH_WORDS = 1024
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic        start,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        WE_i_mem,
  output logic [31:0] WD_i_mem,
  output logic [9:0]  A_i_mem,
  output logic        core_reset,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [2:0]  o_dbg_state
);

  // Handshake: a byte moves only on a rising edge where rx_valid && rx_ready;
  // rx_ready is registered and depends only on state, never on rx_valid.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_LO = 3'd1,
    S_LEN_HI = 3'd2,
    S_DATA   = 3'd3,
    S_WRITE  = 3'd4,
    S_CHK    = 3'd5,
    S_FAIL   = 3'd6
  } state_t;

  localparam logic [16:0] DEPTH_L = 17'(DEPTH_WORDS);

  state_t      r_state;
  logic [15:0] r_len;
  logic [15:0] r_word_cnt;
  logic [1:0]  r_byte_idx;
  logic [7:0]  r_csum;
  logic        r_rx_ready;
  logic        r_we;
  logic [31:0] r_wd;
  logic [9:0]  r_addr;
  logic        r_core_reset;
  logic        r_busy;
  logic        r_done;
  logic        r_error;

  logic        w_accept;
  logic [15:0] w_len_full;
  logic        w_len_bad;
  logic [15:0] w_next_cnt;

  assign w_accept   = rx_valid & r_rx_ready;
  assign w_len_full = {rx_data, r_len[7:0]};
  assign w_len_bad  = (w_len_full == 16'd0) || ({1'b0, w_len_full} > DEPTH_L);
  assign w_next_cnt = r_word_cnt + 16'd1;

  always_ff @(posedge clk) begin
    if (Reset) begin
      r_state      <= S_IDLE;
      r_len        <= '0;
      r_word_cnt   <= '0;
      r_byte_idx   <= '0;
      r_csum       <= '0;
      r_rx_ready   <= 1'b0;
      r_we         <= 1'b0;
      r_wd         <= '0;
      r_addr       <= '0;
      r_core_reset <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_we   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state      <= S_LEN_LO;
            r_rx_ready   <= 1'b1;
            r_core_reset <= 1'b1;
            r_busy       <= 1'b1;
            r_error      <= 1'b0;
            r_word_cnt   <= '0;
            r_csum       <= '0;
            r_byte_idx   <= '0;
            r_len        <= '0;
            r_addr       <= '0;
          end
        end
        S_LEN_LO: begin
          if (w_accept) begin
            r_len[7:0] <= rx_data;
            r_state    <= S_LEN_HI;
          end
        end
        S_LEN_HI: begin
          if (w_accept) begin
            r_len[15:8] <= rx_data;
            if (w_len_bad) begin
              r_state    <= S_FAIL;
              r_rx_ready <= 1'b0;
              r_error    <= 1'b1;
              r_busy     <= 1'b0;
            end else begin
              r_state <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (w_accept) begin
            r_wd[{r_byte_idx, 3'b000} +: 8] <= rx_data;
            r_csum     <= r_csum ^ rx_data;
            r_byte_idx <= r_byte_idx + 2'd1;
            if (r_byte_idx == 2'd3) begin
              r_state    <= S_WRITE;
              r_rx_ready <= 1'b0;
              r_we       <= 1'b1;
              r_addr     <= r_word_cnt[9:0];
            end
          end
        end
        S_WRITE: begin
          // Word count never exceeds the accepted length, so the address cannot wrap.
          r_word_cnt <= w_next_cnt;
          r_rx_ready <= 1'b1;
          r_state    <= (w_next_cnt < r_len) ? S_DATA : S_CHK;
        end
        S_CHK: begin
          if (w_accept) begin
            r_rx_ready <= 1'b0;
            if (rx_data == r_csum) begin
              r_state      <= S_IDLE;
              r_done       <= 1'b1;
              r_core_reset <= 1'b0;
              r_busy       <= 1'b0;
            end else begin
              r_state <= S_FAIL;
              r_error <= 1'b1;
              r_busy  <= 1'b0;
            end
          end
        end
        S_FAIL: begin
          // error and core_reset stay asserted until the next start or Reset.
          r_state <= S_IDLE;
        end
        default: begin
          r_state    <= S_IDLE;
          r_rx_ready <= 1'b0;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

  assign rx_ready    = r_rx_ready;
  assign WE_i_mem    = r_we;
  assign WD_i_mem    = r_wd;
  assign A_i_mem     = r_addr;
  assign core_reset  = r_core_reset;
  assign busy        = r_busy;
  assign done        = r_done;
  assign error       = r_error;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: header checks, checksum pass/fail,
// stalled stream with ignored starts, reset during a write, and a full-depth load.
module tb_program_loader;

  logic        clk = 1'b0;
  logic        Reset;
  logic        start;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        WE_i_mem;
  logic [31:0] WD_i_mem;
  logic [9:0]  A_i_mem;
  logic        core_reset;
  logic        busy;
  logic        done;
  logic        error;
  logic [2:0]  o_dbg_state;

  program_loader #(.DEPTH_WORDS(1024)) dut (
    .clk        (clk),
    .Reset      (Reset),
    .start      (start),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .WE_i_mem   (WE_i_mem),
    .WD_i_mem   (WD_i_mem),
    .A_i_mem    (A_i_mem),
    .core_reset (core_reset),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .o_dbg_state(o_dbg_state)
  );

  // Clock / cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int overlap_cnt = 0;
  int t0 = 0;

  logic [41:0] exp_q[$];
  logic [41:0] got_q[$];
  logic [31:0] words_q[$];

  // Write monitor: records every memory write as {addr, data}
  always @(negedge clk) begin
    if (WE_i_mem) got_q.push_back({A_i_mem, WD_i_mem});
    if (WE_i_mem && rx_ready) overlap_cnt++;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap, input bit pulse);
    int n;
    for (int i = 0; i < gap; i++) begin
      @(negedge clk);
      rx_valid = 1'b0;
    end
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    start    = pulse;
    n = 0;
    while (!rx_ready && n < 100) begin
      @(negedge clk);
      start = 1'b0;
      n++;
    end
    if (n >= 100) check("rx_ready_timeout", rx_ready, 1'b1);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic idle_rx();
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic do_start();
    @(negedge clk);
    rx_valid = 1'b0;
    start    = 1'b1;
    t0       = cyc;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("start_busy", busy, 1'b1);
    check("start_core_reset", core_reset, 1'b1);
    check("start_error_clr", error, 1'b0);
    check("start_rx_ready", rx_ready, 1'b1);
  endtask

  task automatic send_payload(input int maxgap, input bit pulses, output logic [7:0] cs);
    logic [31:0] w;
    cs = 8'h00;
    for (int i = 0; i < words_q.size(); i++) begin
      w = words_q[i];
      exp_q.push_back({10'(i), w});
      for (int k = 0; k < 4; k++) begin
        cs = cs ^ w[8*k +: 8];
        send_byte(w[8*k +: 8], $urandom_range(0, maxgap),
                  pulses && ($urandom_range(0, 2) == 0));
      end
    end
  endtask

  task automatic compare_writes(input string tag);
    check({tag, "_wr_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      check({tag, "_wr"}, got_q[i], exp_q[i]);
  endtask

  task automatic clear_sb();
    got_q.delete();
    exp_q.delete();
    words_q.delete();
    done_cnt = 0;
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_rx_ready"}, rx_ready, 1'b0);
    check({tag, "_we"}, WE_i_mem, 1'b0);
    check({tag, "_wd"}, WD_i_mem, 32'h0);
    check({tag, "_addr"}, A_i_mem, 10'h0);
    check({tag, "_core_reset"}, core_reset, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_error"}, error, 1'b0);
    check({tag, "_state"}, o_dbg_state, 3'd0);
  endtask

  task automatic load_two_ok(input string tag);
    logic [7:0] cs;
    clear_sb();
    words_q.push_back(32'h00A00513);
    words_q.push_back(32'h00B00593);
    do_start();
    send_byte(8'h02, 0, 1'b0);
    send_byte(8'h00, 0, 1'b0);
    send_payload(0, 1'b0, cs);
    // XOR of 13 05 A0 00 93 05 B0 00 is 0x90
    send_byte(8'h90, 0, 1'b0);
    idle_rx();
    check({tag, "_done_pulse"}, done, 1'b1);
    check({tag, "_core_release"}, core_reset, 1'b0);
    check({tag, "_busy_low"}, busy, 1'b0);
    @(negedge clk);
    check({tag, "_done_one_cycle"}, done, 1'b0);
    repeat (2) @(negedge clk);
    check({tag, "_done_cnt"}, done_cnt, 1);
    check({tag, "_error"}, error, 1'b0);
    compare_writes(tag);
  endtask

  initial begin
    logic [7:0]  cs;
    logic [31:0] w;

    // Reset state
    Reset = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_outs("reset");
    Reset = 1'b0;
    @(negedge clk);

    // Two-word load with correct checksum
    load_two_ok("load2");

    // Length zero
    clear_sb();
    do_start();
    send_byte(8'h00, 0, 1'b0);
    send_byte(8'h00, 0, 1'b0);
    idle_rx();
    check("len0_error", error, 1'b1);
    check("len0_busy", busy, 1'b0);
    repeat (3) @(negedge clk);
    check("len0_error_sticky", error, 1'b1);
    check("len0_core_reset", core_reset, 1'b1);
    check("len0_rx_ready", rx_ready, 1'b0);
    check("len0_no_write", got_q.size(), 0);

    // Length 0x0401 exceeds depth
    clear_sb();
    do_start();
    send_byte(8'h01, 0, 1'b0);
    send_byte(8'h04, 0, 1'b0);
    idle_rx();
    repeat (3) @(negedge clk);
    check("len401_error", error, 1'b1);
    check("len401_core_reset", core_reset, 1'b1);
    check("len401_no_write", got_q.size(), 0);

    // Wrong checksum
    clear_sb();
    words_q.push_back(32'h00A00513);
    words_q.push_back(32'h00B00593);
    do_start();
    send_byte(8'h02, 0, 1'b0);
    send_byte(8'h00, 0, 1'b0);
    send_payload(0, 1'b0, cs);
    send_byte(8'h00, 0, 1'b0);
    idle_rx();
    repeat (3) @(negedge clk);
    check("badcs_error", error, 1'b1);
    check("badcs_no_done", done_cnt, 0);
    check("badcs_core_reset", core_reset, 1'b1);
    check("badcs_busy", busy, 1'b0);
    compare_writes("badcs");

    // Three words with rx_valid gaps and start pulses mid-load
    clear_sb();
    words_q.push_back(32'hDEADBEEF);
    words_q.push_back(32'h12345678);
    words_q.push_back(32'h0F1E2D3C);
    do_start();
    send_byte(8'h03, 2, 1'b1);
    send_byte(8'h00, 1, 1'b1);
    send_payload(3, 1'b1, cs);
    send_byte(cs, 2, 1'b0);
    idle_rx();
    repeat (3) @(negedge clk);
    check("gap_done_cnt", done_cnt, 1);
    check("gap_error", error, 1'b0);
    check("gap_core_reset", core_reset, 1'b0);
    check("gap_we_vs_ready", overlap_cnt, 0);
    compare_writes("gap");

    // Reset on the WRITE cycle of word 1
    clear_sb();
    do_start();
    send_byte(8'h02, 0, 1'b0);
    send_byte(8'h00, 0, 1'b0);
    w = 32'hCAFEF00D;
    exp_q.push_back({10'd0, w});
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], 0, 1'b0);
    w = 32'hA5A55A5A;
    exp_q.push_back({10'd1, w});
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], 0, 1'b0);
    Reset = 1'b1;
    rx_valid = 1'b0;
    @(negedge clk);
    check("rst_write_cycle_we", WE_i_mem, 1'b1);
    @(negedge clk);
    check_reset_outs("rst_mid");
    Reset = 1'b0;
    repeat (3) @(negedge clk);
    compare_writes("rst_mid");
    check("rst_no_done", done_cnt, 0);
    load_two_ok("after_rst");

    // Full-depth load, rx_valid held high
    clear_sb();
    for (int i = 0; i < 1024; i++) begin
      w = {8'(i + 3), 8'(i * 7), 8'(i >> 2), 8'(i)};
      words_q.push_back(w);
    end
    do_start();
    send_byte(8'h00, 0, 1'b0);
    send_byte(8'h04, 0, 1'b0);
    send_payload(0, 1'b0, cs);
    send_byte(cs, 0, 1'b0);
    idle_rx();
    check("full_done_pulse", done, 1'b1);
    @(negedge clk);
    check("full_cycles", done_cyc - t0, 5 * 1024 + 4);
    check("full_done_cnt", done_cnt, 1);
    check("full_error", error, 1'b0);
    check("full_last_addr", A_i_mem, 10'd1023);
    check("full_we_vs_ready", overlap_cnt, 0);
    compare_writes("full");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
